deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel front end of the message datapath. It accepts one serial bit per strobe, MSB first, and assembles a MSG_SIZE-bit word. It exports the word together with a bit counter. The downstream serializer stage starts when that counter equals MSG_SIZE, and it relies on both the word and the counter staying stable until the next frame is explicitly cleared.

## Interface

Parameters:
- MSG_SIZE, default 64: message width in bits; legal range ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  global enable; when low, all state holds.
- iData_in  input  1  serial data bit, sampled when iData_valid=1.
- iData_valid  input  1  bit strobe; one bit accepted per cycle while high.
- iClear  input  1  frame restart; synchronous; returns the block to the empty state.
- oData_out  output  MSG_SIZE  assembled word; first bit received ends up in the MSB.
- oCounter  output  $clog2(MSG_SIZE)+1  number of bits accepted, 0..MSG_SIZE.
- oFull  output  1  high while oCounter == MSG_SIZE.
- oOverrun  output  1  sticky; set when a bit is strobed while full.

## Operation

- Reset values:
  - oData_out=0, oCounter=0, oFull=0, oOverrun=0.
  - State FILL.
- FSM states: FILL and FULL.
- FILL, on ena & iData_valid & !iClear:
  - oData_out <= {oData_out[MSG_SIZE-2:0], iData_in}.
  - oCounter <= oCounter+1.
  - When the incremented count equals MSG_SIZE, go to FULL and set oFull in the same edge.
- FULL:
  - oData_out and oCounter are frozen.
  - On ena & iData_valid & !iClear, set oOverrun=1 and drop the bit.
  - There is no wrap-around: oCounter never exceeds MSG_SIZE and never returns to 0 except via iClear or reset.
- iClear (qualified by ena):
  - oData_out=0, oCounter=0, oFull=0, oOverrun=0; state FILL.
  - iClear has priority over a simultaneous iData_valid; that bit is discarded and not counted.
- ena low: iData_valid and iClear are both ignored; all outputs hold.
- Counter width is $clog2(MSG_SIZE)+1 bits, so MSG_SIZE itself is representable. Arithmetic is unsigned.

## Timing

- All outputs are registered; no combinational path from inputs to outputs.
- Latency: a bit strobed at edge N appears in oData_out[0], and oCounter increments, after edge N.
- After the MSG_SIZE-th accepted bit, oFull and oCounter==MSG_SIZE are visible the cycle after that edge. The downstream stage can start from that cycle.
- Back-to-back strobes are allowed every cycle. The minimum frame time is MSG_SIZE cycles from the first strobe to oFull.
- Gaps in iData_valid are allowed; partial state holds indefinitely.
- Reset asserted mid-frame immediately forces all reset values, asynchronously. The first accepted bit after deassertion is treated as bit 0 of a new frame.
- iClear in the same cycle as the final bit: the frame is discarded, and oFull never asserts.

## Structure

- Shared message package holds:
  - the default MSG_SIZE constant;
  - a counter-width function/constant, $clog2(MSG_SIZE)+1, used by this block and by the serializer so their counter ports always match;
  - the FILL/FULL state encoding as a typedef/localparams.
- Single module; no sub-module needed.
- The shift register and counter are simple enough to stay inline alongside the two-state FSM.

## Test plan

All scenarios use MSG_SIZE=8.

- Reset values: hold rst_n low; check all outputs are 0. Release, then strobe 0xA5 MSB-first on 8 consecutive cycles. Required: oData_out=0xA5, oCounter=8, oFull=1 the cycle after the 8th strobe, oOverrun=0.
- Gapped strobes and overrun: strobe 1,0,1,1,0,0,1,1 with 1–3 idle cycles between bits. Required: oData_out=0xB3, oCounter=8. Then one extra strobe. Required: oOverrun=1 and oData_out still 0xB3.
- Clear priority: send 8 bits of 0xFF, with iClear high on the 8th strobe cycle. Required: oCounter=0, oData_out=0x00, oFull never asserts. Then strobe 0x3C. Required: oData_out=0x3C, oCounter=8, oFull=1.
- Enable gating: mid-frame after 4 bits (oCounter=4), drive ena=0 with iData_valid=1 and iClear=1 for 5 cycles. Required: oCounter stays 4 and oData_out is unchanged. With ena=1, 4 more bits complete the frame.
- Asynchronous reset mid-frame: after 5 bits, pulse rst_n low between clock edges. Required: immediate oCounter=0 and oData_out=0. A new 8-bit frame of 0x5A then yields oData_out=0x5A and oCounter=8.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared message-path definitions: default word size, counter width helper
// and the fill/full state encoding used by the deserializer and serializer.
package deserializer_pkg;

   localparam int MSG_SIZE_DEFAULT = 64;

   // One extra bit so that a count equal to the full message size fits.
   function automatic int cnt_width(input int msg_size);
      return $clog2(msg_size) + 1;
   endfunction

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } deser_state_t;

endpackage

// File: rtl/deserializer_if.sv
// Bus between the serial source / downstream serializer and the deserializer.
interface deserializer_if
   import deserializer_pkg::*;
#(
   parameter int MSG_SIZE = MSG_SIZE_DEFAULT
) ();

   localparam int CW = cnt_width(MSG_SIZE);

   logic                ena;
   logic                iData_in;
   logic                iData_valid;
   logic                iClear;
   logic [MSG_SIZE-1:0] oData_out;
   logic [CW-1:0]       oCounter;
   logic                oFull;
   logic                oOverrun;

   modport master (
      output ena, iData_in, iData_valid, iClear,
      input  oData_out, oCounter, oFull, oOverrun
   );

   modport slave (
      input  ena, iData_in, iData_valid, iClear,
      output oData_out, oCounter, oFull, oOverrun
   );

endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel front end: shifts in MSB-first bits until MSG_SIZE are held,
// then freezes word and count until an explicit clear.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int MSG_SIZE = MSG_SIZE_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   deserializer_if.slave bus
);

   localparam int CW = cnt_width(MSG_SIZE);
   localparam logic [CW-1:0] FULL_COUNT = CW'(MSG_SIZE);

   deser_state_t        r_state;
   logic [MSG_SIZE-1:0] r_data;
   logic [CW-1:0]       r_cnt;
   logic                r_ovr;

   deser_state_t        w_state_next;
   logic [MSG_SIZE-1:0] w_data_next;
   logic [CW-1:0]       w_cnt_next;
   logic                w_ovr_next;
   logic [CW-1:0]       w_cnt_inc;

   assign w_cnt_inc = r_cnt + 1'b1;

   always_comb begin
      w_state_next = r_state;
      w_data_next  = r_data;
      w_cnt_next   = r_cnt;
      w_ovr_next   = r_ovr;
      if (bus.ena) begin
         // Clear wins over a simultaneous strobe; that bit is simply dropped.
         if (bus.iClear) begin
            w_state_next = ST_FILL;
            w_data_next  = '0;
            w_cnt_next   = '0;
            w_ovr_next   = 1'b0;
         end else if (bus.iData_valid) begin
            case (r_state)
               ST_FILL: begin
                  w_data_next = {r_data[MSG_SIZE-2:0], bus.iData_in};
                  w_cnt_next  = w_cnt_inc;
                  if (w_cnt_inc == FULL_COUNT) begin
                     w_state_next = ST_FULL;
                  end
               end
               ST_FULL: begin
                  w_ovr_next = 1'b1;
               end
               default: begin
                  w_state_next = ST_FILL;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL;
         r_data  <= '0;
         r_cnt   <= '0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_data  <= w_data_next;
         r_cnt   <= w_cnt_next;
         r_ovr   <= w_ovr_next;
      end
   end

   // Full flag comes straight from the state register, so it tracks the count exactly.
   assign bus.oData_out = r_data;
   assign bus.oCounter  = r_cnt;
   assign bus.oFull     = (r_state == ST_FULL);
   assign bus.oOverrun  = r_ovr;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer at MSG_SIZE=8.
module tb_deserializer;

   localparam int MSG_SIZE = 8;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   deserializer_if #(.MSG_SIZE(MSG_SIZE)) bus ();

   deserializer #(.MSG_SIZE(MSG_SIZE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge, are captured on the next rising edge,
   // and results are sampled on the following falling edge.
   task automatic drive(input logic v, input logic d, input logic c);
      bus.iData_valid = v;
      bus.iData_in    = d;
      bus.iClear      = c;
      @(negedge clk);
      bus.iData_valid = 1'b0;
      bus.iData_in    = 1'b0;
      bus.iClear      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) drive(1'b1, w[i], 1'b0);
   endtask

   task automatic test_reset();
      logic [7:0] w;
      w = 8'hA5;
      rst_n = 1'b0;
      bus.ena = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.oData_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h expected 0", bus.oData_out); end
      total++; if (bus.oCounter !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d expected 0", bus.oCounter); end
      total++; if (bus.oFull !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b expected 0", bus.oFull); end
      total++; if (bus.oOverrun !== 1'b0) begin bad++; $display("FAIL reset_ovr: got %0b expected 0", bus.oOverrun); end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 7; i >= 1; i--) drive(1'b1, w[i], 1'b0);
      total++; if (bus.oCounter !== 4'd7 || bus.oFull !== 1'b0) begin bad++; $display("FAIL a5_seven: got cnt=%0d full=%0b expected cnt=7 full=0", bus.oCounter, bus.oFull); end
      drive(1'b1, w[0], 1'b0);
      total++; if (bus.oData_out !== 8'hA5) begin bad++; $display("FAIL a5_data: got %0h expected a5", bus.oData_out); end
      total++; if (bus.oCounter !== 4'd8) begin bad++; $display("FAIL a5_cnt: got %0d expected 8", bus.oCounter); end
      total++; if (bus.oFull !== 1'b1) begin bad++; $display("FAIL a5_full: got %0b expected 1", bus.oFull); end
      total++; if (bus.oOverrun !== 1'b0) begin bad++; $display("FAIL a5_ovr: got %0b expected 0", bus.oOverrun); end
      $display("test_reset: data=%0h cnt=%0d full=%0b", bus.oData_out, bus.oCounter, bus.oFull);
   endtask

   task automatic test_gapped_overrun();
      logic [7:0] w;
      w = 8'b1011_0011;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) begin
         drive(1'b1, w[i], 1'b0);
         repeat ((i % 3) + 1) drive(1'b0, 1'b1, 1'b0);
      end
      total++; if (bus.oData_out !== 8'hB3) begin bad++; $display("FAIL gap_data: got %0h expected b3", bus.oData_out); end
      total++; if (bus.oCounter !== 4'd8) begin bad++; $display("FAIL gap_cnt: got %0d expected 8", bus.oCounter); end
      total++; if (bus.oOverrun !== 1'b0) begin bad++; $display("FAIL gap_ovr_early: got %0b expected 0", bus.oOverrun); end
      drive(1'b1, 1'b0, 1'b0);
      total++; if (bus.oOverrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %0b expected 1", bus.oOverrun); end
      total++; if (bus.oData_out !== 8'hB3 || bus.oCounter !== 4'd8) begin bad++; $display("FAIL ovr_frozen: got data=%0h cnt=%0d expected data=b3 cnt=8", bus.oData_out, bus.oCounter); end
      drive(1'b0, 1'b0, 1'b0);
      total++; if (bus.oOverrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %0b expected 1", bus.oOverrun); end
      drive(1'b0, 1'b0, 1'b1);
      total++; if (bus.oOverrun !== 1'b0 || bus.oFull !== 1'b0) begin bad++; $display("FAIL ovr_clear: got ovr=%0b full=%0b expected 0 0", bus.oOverrun, bus.oFull); end
      $display("test_gapped_overrun: data=%0h cnt=%0d ovr=%0b", bus.oData_out, bus.oCounter, bus.oOverrun);
   endtask

   task automatic test_clear_priority();
      int full_seen;
      full_seen = 0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         if (bus.oFull === 1'b1) full_seen++;
      end
      drive(1'b1, 1'b1, 1'b1);
      if (bus.oFull === 1'b1) full_seen++;
      drive(1'b0, 1'b0, 1'b0);
      if (bus.oFull === 1'b1) full_seen++;
      total++; if (full_seen !== 0) begin bad++; $display("FAIL clr_full_never: got %0d full cycles expected 0", full_seen); end
      total++; if (bus.oCounter !== 4'd0) begin bad++; $display("FAIL clr_cnt: got %0d expected 0", bus.oCounter); end
      total++; if (bus.oData_out !== 8'h00) begin bad++; $display("FAIL clr_data: got %0h expected 0", bus.oData_out); end
      send_byte(8'h3C);
      total++; if (bus.oData_out !== 8'h3C) begin bad++; $display("FAIL clr_3c_data: got %0h expected 3c", bus.oData_out); end
      total++; if (bus.oCounter !== 4'd8 || bus.oFull !== 1'b1) begin bad++; $display("FAIL clr_3c_full: got cnt=%0d full=%0b expected 8 1", bus.oCounter, bus.oFull); end
      $display("test_clear_priority: data=%0h cnt=%0d full=%0b", bus.oData_out, bus.oCounter, bus.oFull);
   endtask

   task automatic test_enable_gating();
      logic [7:0] w;
      w = 8'hA3;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 7; i >= 4; i--) drive(1'b1, w[i], 1'b0);
      total++; if (bus.oCounter !== 4'd4 || bus.oData_out !== 8'h0A) begin bad++; $display("FAIL ena_pre: got cnt=%0d data=%0h expected 4 0a", bus.oCounter, bus.oData_out); end
      bus.ena = 1'b0;
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
      total++; if (bus.oCounter !== 4'd4) begin bad++; $display("FAIL ena_cnt_hold: got %0d expected 4", bus.oCounter); end
      total++; if (bus.oData_out !== 8'h0A) begin bad++; $display("FAIL ena_data_hold: got %0h expected 0a", bus.oData_out); end
      bus.ena = 1'b1;
      for (int i = 3; i >= 0; i--) drive(1'b1, w[i], 1'b0);
      total++; if (bus.oData_out !== 8'hA3 || bus.oCounter !== 4'd8 || bus.oFull !== 1'b1) begin bad++; $display("FAIL ena_done: got data=%0h cnt=%0d full=%0b expected a3 8 1", bus.oData_out, bus.oCounter, bus.oFull); end
      $display("test_enable_gating: data=%0h cnt=%0d full=%0b", bus.oData_out, bus.oCounter, bus.oFull);
   endtask

   task automatic test_async_reset();
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
      total++; if (bus.oCounter !== 4'd5 || bus.oData_out !== 8'h1F) begin bad++; $display("FAIL arst_pre: got cnt=%0d data=%0h expected 5 1f", bus.oCounter, bus.oData_out); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.oCounter !== 4'd0 || bus.oData_out !== 8'h00) begin bad++; $display("FAIL arst_now: got cnt=%0d data=%0h expected 0 0", bus.oCounter, bus.oData_out); end
      #1 rst_n = 1'b1;
      @(negedge clk);
      send_byte(8'h5A);
      total++; if (bus.oData_out !== 8'h5A || bus.oCounter !== 4'd8 || bus.oFull !== 1'b1) begin bad++; $display("FAIL arst_5a: got data=%0h cnt=%0d full=%0b expected 5a 8 1", bus.oData_out, bus.oCounter, bus.oFull); end
      $display("test_async_reset: data=%0h cnt=%0d full=%0b", bus.oData_out, bus.oCounter, bus.oFull);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.ena = 1'b1;
      bus.iData_in = 1'b0;
      bus.iData_valid = 1'b0;
      bus.iClear = 1'b0;
      @(negedge clk);
      test_reset();
      test_gapped_overrun();
      test_clear_priority();
      test_enable_gating();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
